obi_apb_splitter: RTL and testbench

//  Parametrised single-initiator OBI to NUM_APB x APB3/APB4 bridge for subsystem control buses.

---
 rtl/obi_apb_splitter_pkg.sv | 41 ++++
 rtl/obi_apb_decode.sv | 33 +++
 rtl/obi_apb_splitter.sv | 200 ++++++++++++++++++++
 tb/tb_obi_apb_splitter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/obi_apb_splitter_pkg.sv
// Shared types and address-decode helper for the OBI to APB splitter.
// Optional ACCESS watchdog in the top is enabled by defining OBI_APB_TIMEOUT_EN.
package obi_apb_splitter_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ACCESS   = 3'd2,
        RESP     = 3'd3,
        ERR_RESP = 3'd4
    } state_e;

    typedef struct packed {
        logic [3:0]  idx;
        logic [31:0] start_addr;
        logic [31:0] end_addr;
    } addr_rule_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] idx;
    } dec_t;

    // Window 0 (lowest addresses) belongs to the highest target index.
    function automatic dec_t decode_idx(input logic [31:0] addr, input logic [31:0] base,
                                        input logic [31:0] size, input logic [4:0] n);
        dec_t        d;
        logic [31:0] off;
        logic [4:0]  win;
        off   = addr - base;
        win   = 5'(off / size);
        d.hit = (addr >= base) && (off < (size * {27'd0, n}));
        d.idx = d.hit ? 4'(n - 5'd1 - win) : 4'd0;
        return d;
    endfunction

    function automatic logic inv_par(input logic bit_in);
        return ~bit_in;
    endfunction

endpackage

// File: rtl/obi_apb_decode.sv
// Combinational address decoder: byte address -> {hit, one-hot select, target index}.
module obi_apb_decode
    import obi_apb_splitter_pkg::*;
#(
    parameter int unsigned NUM_APB   = 4,
    parameter logic [31:0] ADDR_BASE = 32'h0105_0000,
    parameter logic [31:0] SS_SIZE   = 32'h0000_1000,
    parameter int unsigned IDXW      = (NUM_APB > 1) ? $clog2(NUM_APB) : 1
) (
    input  logic [31:0]        addr,
    output logic               hit,
    output logic [NUM_APB-1:0] onehot,
    output logic [IDXW-1:0]    idx
);

    dec_t dec_s;
    logic unused_dec_s;

    assign dec_s        = decode_idx(addr, ADDR_BASE, SS_SIZE, 5'(NUM_APB));
    assign hit          = dec_s.hit;
    assign idx          = dec_s.idx[IDXW-1:0];
    assign unused_dec_s = ^dec_s;

    for (genvar i = 0; i < NUM_APB; i++) begin : g_rule
        localparam addr_rule_t RULE = '{
            idx:        4'(i),
            start_addr: 32'(ADDR_BASE + SS_SIZE * (NUM_APB - 1 - i)),
            end_addr:   32'(ADDR_BASE + SS_SIZE * (NUM_APB - i))
        };
        assign onehot[i] = (addr >= RULE.start_addr) && (addr < RULE.end_addr);
    end

endmodule

// File: rtl/obi_apb_splitter.sv
// Single-initiator OBI to NUM_APB x APB3/APB4 bridge, one transaction outstanding.
// Define OBI_APB_TIMEOUT_EN to add an ACCESS-phase watchdog that errors out stuck targets.
module obi_apb_splitter
    import obi_apb_splitter_pkg::*;
#(
    parameter int unsigned NUM_APB        = 4,
    parameter int unsigned OBI_AW         = 32,
    parameter int unsigned OBI_DW         = 32,
    parameter int unsigned OBI_IDW        = 1,
    parameter int unsigned APB_AW         = 32,
    parameter int unsigned APB_DW         = 32,
    parameter logic [31:0] ADDR_BASE      = 32'h0105_0000,
    parameter logic [31:0] SS_SIZE        = 32'h0000_1000,
    parameter int unsigned SS_CTRL_W      = 7,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      obi_req,
    output logic                      obi_gnt,
    input  logic [OBI_AW-1:0]         obi_addr,
    input  logic                      obi_we,
    input  logic [OBI_DW/8-1:0]       obi_be,
    input  logic [OBI_DW-1:0]         obi_wdata,
    input  logic [OBI_IDW-1:0]        obi_aid,
    input  logic                      obi_reqpar,
    input  logic                      obi_rreadypar,
    output logic                      obi_rvalid,
    input  logic                      obi_rready,
    output logic [OBI_DW-1:0]         obi_rdata,
    output logic                      obi_err,
    output logic [OBI_IDW-1:0]        obi_rid,
    output logic                      obi_gntpar,
    output logic                      obi_rvalidpar,
    input  logic [SS_CTRL_W-1:0]      ss_ctrl_icn,
    output logic [NUM_APB-1:0]        apb_psel,
    output logic                      apb_penable,
    output logic                      apb_pwrite,
    output logic [APB_AW-1:0]         apb_paddr,
    output logic [APB_DW-1:0]         apb_pwdata,
    output logic [APB_DW/8-1:0]       apb_pstrb,
    input  logic [NUM_APB*APB_DW-1:0] apb_prdata,
    input  logic [NUM_APB-1:0]        apb_pready,
    input  logic [NUM_APB-1:0]        apb_pslverr
);

    localparam int unsigned IDXW = (NUM_APB > 1) ? $clog2(NUM_APB) : 1;

    state_e               state_r;
    logic [NUM_APB-1:0]   psel_r;
    logic                 penable_r;
    logic                 pwrite_r;
    logic [APB_AW-1:0]    paddr_r;
    logic [APB_DW-1:0]    pwdata_r;
    logic [APB_DW/8-1:0]  pstrb_r;
    logic                 we_r;
    logic [IDXW-1:0]      idx_r;
    logic                 rvalid_r;
    logic [OBI_DW-1:0]    rdata_r;
    logic                 err_r;
    logic [OBI_IDW-1:0]   rid_r;

    logic                 dec_hit_s;
    logic [NUM_APB-1:0]   dec_onehot_s;
    logic [IDXW-1:0]      dec_idx_s;
    logic [APB_DW-1:0]    prdata_sel_s;
    logic                 unused_s;

`ifdef OBI_APB_TIMEOUT_EN
    localparam int unsigned TMO_RAW = $clog2(TIMEOUT_CYCLES);
    localparam int unsigned TMO_W   = (TMO_RAW < 8) ? 8 : ((TMO_RAW > 32) ? 32 : TMO_RAW);
    logic [TMO_W-1:0] tmo_cnt_r;
`endif

    obi_apb_decode #(
        .NUM_APB   (NUM_APB),
        .ADDR_BASE (ADDR_BASE),
        .SS_SIZE   (SS_SIZE),
        .IDXW      (IDXW)
    ) u_decode (
        .addr   (obi_addr),
        .hit    (dec_hit_s),
        .onehot (dec_onehot_s),
        .idx    (dec_idx_s)
    );

    assign obi_gnt       = (state_r == IDLE) && obi_req;
    assign obi_gntpar    = inv_par(obi_gnt);
    assign obi_rvalid    = rvalid_r;
    assign obi_rvalidpar = inv_par(rvalid_r);
    assign obi_rdata     = rdata_r;
    assign obi_err       = err_r;
    assign obi_rid       = rid_r;
    assign apb_psel      = psel_r;
    assign apb_penable   = penable_r;
    assign apb_pwrite    = pwrite_r;
    assign apb_paddr     = paddr_r;
    assign apb_pwdata    = pwdata_r;
    assign apb_pstrb     = pstrb_r;
    assign prdata_sel_s  = apb_prdata[idx_r*APB_DW +: APB_DW];
    assign unused_s      = ^{obi_reqpar, obi_rreadypar, ss_ctrl_icn[SS_CTRL_W-1:1],
                             TIMEOUT_CYCLES[0]};

    // Bridge FSM; all APB and OBI response outputs are registered here.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= IDLE;
            psel_r    <= '0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= '0;
            pwdata_r  <= '0;
            pstrb_r   <= '0;
            we_r      <= 1'b0;
            idx_r     <= '0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            err_r     <= 1'b0;
            rid_r     <= '0;
`ifdef OBI_APB_TIMEOUT_EN
            tmo_cnt_r <= '0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (obi_req) begin
                        rid_r <= obi_aid;
                        we_r  <= obi_we;
                        idx_r <= dec_idx_s;
                        // Enable is sampled only here, so in-flight accesses are unaffected.
                        if (dec_hit_s && ss_ctrl_icn[0]) begin
                            psel_r   <= dec_onehot_s;
                            pwrite_r <= obi_we;
                            paddr_r  <= obi_addr[APB_AW-1:0];
                            pwdata_r <= obi_wdata;
                            pstrb_r  <= obi_be;
                            state_r  <= SETUP;
                        end else begin
                            rvalid_r <= 1'b1;
                            err_r    <= 1'b1;
                            rdata_r  <= '0;
                            state_r  <= ERR_RESP;
                        end
                    end
                end
                SETUP: begin
                    penable_r <= 1'b1;
                    state_r   <= ACCESS;
`ifdef OBI_APB_TIMEOUT_EN
                    tmo_cnt_r <= '0;
`endif
                end
                ACCESS: begin
                    if (apb_pready[idx_r]) begin
                        rdata_r   <= we_r ? '0 : prdata_sel_s;
                        err_r     <= apb_pslverr[idx_r];
                        rvalid_r  <= 1'b1;
                        psel_r    <= '0;
                        penable_r <= 1'b0;
                        pwrite_r  <= 1'b0;
                        paddr_r   <= '0;
                        pwdata_r  <= '0;
                        pstrb_r   <= '0;
                        state_r   <= RESP;
`ifdef OBI_APB_TIMEOUT_EN
                    end else if (tmo_cnt_r == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        rdata_r   <= '0;
                        err_r     <= 1'b1;
                        rvalid_r  <= 1'b1;
                        psel_r    <= '0;
                        penable_r <= 1'b0;
                        pwrite_r  <= 1'b0;
                        paddr_r   <= '0;
                        pwdata_r  <= '0;
                        pstrb_r   <= '0;
                        state_r   <= RESP;
                    end else begin
                        tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
`endif
                    end
                end
                RESP, ERR_RESP: begin
                    if (obi_rready) begin
                        rvalid_r <= 1'b0;
                        err_r    <= 1'b0;
                        rdata_r  <= '0;
                        state_r  <= IDLE;
                    end
                end
                default: begin
                    psel_r    <= '0;
                    penable_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_obi_apb_splitter.sv
// Directed self-checking bench for obi_apb_splitter (default 4-target configuration).
module tb_obi_apb_splitter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         obi_req, obi_gnt, obi_we, obi_reqpar, obi_rreadypar;
    logic [31:0]  obi_addr, obi_wdata, obi_rdata;
    logic [3:0]   obi_be;
    logic [0:0]   obi_aid, obi_rid;
    logic         obi_rvalid, obi_rready, obi_err, obi_gntpar, obi_rvalidpar;
    logic [6:0]   ss_ctrl_icn;
    logic [3:0]   apb_psel, apb_pstrb, apb_pready, apb_pslverr;
    logic         apb_penable, apb_pwrite;
    logic [31:0]  apb_paddr, apb_pwdata;
    logic [127:0] apb_prdata;

    int checks   = 0;
    int failures = 0;

    int          psel_cnt, lat, first_pen;
    logic [3:0]  seen_psel, seen_pstrb;
    logic        seen_pwrite;
    logic [31:0] seen_paddr, seen_pwdata;

    always #5 clk = ~clk;

    obi_apb_splitter dut (
        .clk(clk), .reset_n(reset_n),
        .obi_req(obi_req), .obi_gnt(obi_gnt), .obi_addr(obi_addr), .obi_we(obi_we),
        .obi_be(obi_be), .obi_wdata(obi_wdata), .obi_aid(obi_aid),
        .obi_reqpar(obi_reqpar), .obi_rreadypar(obi_rreadypar),
        .obi_rvalid(obi_rvalid), .obi_rready(obi_rready), .obi_rdata(obi_rdata),
        .obi_err(obi_err), .obi_rid(obi_rid), .obi_gntpar(obi_gntpar),
        .obi_rvalidpar(obi_rvalidpar), .ss_ctrl_icn(ss_ctrl_icn),
        .apb_psel(apb_psel), .apb_penable(apb_penable), .apb_pwrite(apb_pwrite),
        .apb_paddr(apb_paddr), .apb_pwdata(apb_pwdata), .apb_pstrb(apb_pstrb),
        .apb_prdata(apb_prdata), .apb_pready(apb_pready), .apb_pslverr(apb_pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] addr, input logic we, input logic [3:0] be,
                         input logic [31:0] wdata, input logic aid);
        obi_req = 1'b1; obi_addr = addr; obi_we = we; obi_be = be;
        obi_wdata = wdata; obi_aid = aid;
        #1;
        chk("gnt_in_idle", obi_gnt, 1);
        tick();
        obi_req = 1'b0;
    endtask

    // Plays the selected target: pready rises after `waits` low ACCESS cycles.
    task automatic run_to_rvalid(input int waits);
        int acc = 0;
        psel_cnt = 0; lat = 0; first_pen = 0; seen_psel = '0;
        seen_pstrb = '0; seen_pwrite = 1'b0; seen_paddr = '0; seen_pwdata = '0;
        for (int n = 0; n < 60; n++) begin
            if (obi_rvalid) break;
            if (n == 0) first_pen = int'(apb_penable);
            if (apb_psel != 4'b0000) begin
                psel_cnt++;
                seen_psel   = seen_psel | apb_psel;
                seen_pstrb  = apb_pstrb;
                seen_pwrite = apb_pwrite;
                seen_paddr  = apb_paddr;
                seen_pwdata = apb_pwdata;
                if (apb_penable) begin
                    acc++;
                    if (acc > waits) apb_pready = apb_psel;
                end
            end
            tick();
            lat++;
        end
        apb_pready = 4'b0000;
        chk("rvalid_seen", obi_rvalid, 1);
    endtask

    task automatic handshake();
        obi_rready = 1'b1;
        tick();
        obi_rready = 1'b0;
        chk("rvalid_dropped", obi_rvalid, 0);
    endtask

    initial begin
        reset_n = 1'b0; obi_req = 1'b0; obi_addr = '0; obi_we = 1'b0; obi_be = '0;
        obi_wdata = '0; obi_aid = '0; obi_reqpar = 1'b0; obi_rreadypar = 1'b0;
        obi_rready = 1'b0; ss_ctrl_icn = 7'b0000001; apb_pready = '0; apb_pslverr = '0;
        apb_prdata = {32'hD8D8_0004, 32'hC7C7_0003, 32'hB6B6_0002, 32'hA5A5_0001};
        repeat (3) tick();
        chk("rst_psel", apb_psel, 0);
        chk("rst_rvalid", obi_rvalid, 0);
        chk("rst_gntpar", obi_gntpar, 1);
        chk("rst_rvalidpar", obi_rvalidpar, 1);
        chk("rst_paddr", apb_paddr, 0);
        reset_n = 1'b1;
        tick();

        // 1: read target 0 with two wait states
        issue(32'h0105_3004, 1'b0, 4'b1111, 32'h0, 1'b1);
        run_to_rvalid(2);
        chk("t1_psel_cnt", psel_cnt, 4);
        chk("t1_psel", seen_psel, 4'b0001);
        chk("t1_setup_pen", first_pen, 0);
        chk("t1_paddr", seen_paddr, 32'h0105_3004);
        chk("t1_rdata", obi_rdata, 32'hA5A5_0001);
        chk("t1_err", obi_err, 0);
        chk("t1_rid", obi_rid, 1);
        chk("t1_psel_off", apb_psel, 0);
        handshake();

        // 2: write target 3, best-case latency
        issue(32'h0105_0010, 1'b1, 4'b0011, 32'h1234_5678, 1'b0);
        run_to_rvalid(0);
        chk("t2_latency", lat + 1, 3);
        chk("t2_psel", seen_psel, 4'b1000);
        chk("t2_pstrb", seen_pstrb, 4'b0011);
        chk("t2_pwrite", seen_pwrite, 1);
        chk("t2_pwdata", seen_pwdata, 32'h1234_5678);
        chk("t2_rdata", obi_rdata, 0);
        chk("t2_err", obi_err, 0);
        chk("t2_rid", obi_rid, 0);
        handshake();

        // 3a: decode miss just past the last window
        issue(32'h0105_4000, 1'b0, 4'b1111, 32'h0, 1'b1);
        chk("t3a_rvalid", obi_rvalid, 1);
        chk("t3a_err", obi_err, 1);
        chk("t3a_psel", apb_psel, 0);
        chk("t3a_gnt", obi_gnt, 0);
        handshake();

        // 3b: bridge disabled on an otherwise valid address
        ss_ctrl_icn = 7'b1111110;
        issue(32'h0105_1000, 1'b0, 4'b1111, 32'h0, 1'b0);
        chk("t3b_rvalid", obi_rvalid, 1);
        chk("t3b_err", obi_err, 1);
        chk("t3b_rdata", obi_rdata, 0);
        chk("t3b_psel", apb_psel, 0);
        handshake();
        ss_ctrl_icn = 7'b0000001;

        // 4: slave error on target 1 still returns its read data
        apb_pslverr = 4'b0010;
        issue(32'h0105_2000, 1'b0, 4'b1111, 32'h0, 1'b0);
        run_to_rvalid(1);
        chk("t4_psel", seen_psel, 4'b0010);
        chk("t4_err", obi_err, 1);
        chk("t4_rdata", obi_rdata, 32'hB6B6_0002);
        handshake();
        apb_pslverr = 4'b0000;

        // 5: response back-pressure with a request pending
        issue(32'h0105_3004, 1'b0, 4'b1111, 32'h0, 1'b1);
        run_to_rvalid(0);
        obi_req = 1'b1; obi_addr = 32'h0105_0000; obi_we = 1'b1; obi_wdata = 32'hCAFE_0005;
        obi_be = 4'b1111; obi_aid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("t5_rvalid_hold", obi_rvalid, 1);
            chk("t5_rdata_hold", obi_rdata, 32'hA5A5_0001);
            chk("t5_gnt_low", obi_gnt, 0);
            tick();
        end
        obi_rready = 1'b1;
        #1;
        chk("t5_gnt_hs", obi_gnt, 0);
        tick();
        obi_rready = 1'b0;
        chk("t5_rvalid_done", obi_rvalid, 0);
        chk("t5_gnt_after", obi_gnt, 1);
        tick();
        obi_req = 1'b0;
        run_to_rvalid(0);
        chk("t5_psel", seen_psel, 4'b1000);
        chk("t5_rdata", obi_rdata, 0);
        handshake();

        // 6: reset asserted mid-ACCESS
        issue(32'h0105_2000, 1'b0, 4'b1111, 32'h0, 1'b1);
        tick();
        chk("t6_access_pen", apb_penable, 1);
        chk("t6_access_psel", apb_psel, 4'b0010);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_psel", apb_psel, 0);
        chk("t6_async_pen", apb_penable, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t6_no_rvalid", obi_rvalid, 0);
        chk("t6_idle_psel", apb_psel, 0);

`ifdef OBI_APB_TIMEOUT_EN
        issue(32'h0105_3000, 1'b0, 4'b1111, 32'h0, 1'b0);
        lat = 0;
        for (int n = 0; n < 400; n++) begin
            if (obi_rvalid) break;
            tick();
            lat++;
        end
        chk("tmo_rvalid", obi_rvalid, 1);
        chk("tmo_err", obi_err, 1);
        chk("tmo_rdata", obi_rdata, 0);
        chk("tmo_latency", lat, 257);
        handshake();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
